// File: rtl/fpga_config_loader.sv
// Serial configuration receiver: hunts for a sync byte, then shifts in
// ADDR/DATA/CHK and turns each good frame into a one-cycle write strobe.
module fpga_config_loader #(
   parameter int          NUM_TARGETS = 43,
   parameter logic [7:0]  SYNC        = 8'hA5,
   parameter int          DATA_W      = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sin,
   input  logic              sen,
   output logic              cfg_we,
   output logic [7:0]        cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [7:0]        err_count,
   output logic [7:0]        words_loaded,
   output logic              busy
);

   typedef enum logic [2:0] {
      HUNT,
      ADDR,
      DATA,
      CHK,
      EVAL,
      DONE
   } state_t;

   localparam int             CW    = $clog2(DATA_W);
   localparam logic [CW-1:0]  LAST8 = CW'(7);
   localparam logic [CW-1:0]  LASTD = CW'(DATA_W - 1);
   localparam logic [8:0]     NT    = 9'(NUM_TARGETS);

   state_t              state, state_n;
   logic [7:0]          win, win_n, win_s;
   logic [7:0]          sa, sa_n;
   logic [DATA_W-1:0]   sd, sd_n;
   logic [7:0]          sc, sc_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                we_n, err_n, done_n;
   logic [7:0]          oaddr_n, errc_n, words_n;
   logic [DATA_W-1:0]   odata_n;
   logic [7:0]          calc;

   assign busy = (state != HUNT);

   // XOR-fold of address and every data byte, compared against CHK
   always_comb begin
      calc = sa;
      for (int i = 0; i < DATA_W / 8; i++) begin
         calc = calc ^ sd[i*8 +: 8];
      end
   end

   // next-state, shift registers and registered-output next values
   always_comb begin
      state_n = state;
      win_n   = win;
      sa_n    = sa;
      sd_n    = sd;
      sc_n    = sc;
      cnt_n   = cnt;
      we_n    = 1'b0;
      err_n   = 1'b0;
      done_n  = cfg_done;
      oaddr_n = cfg_addr;
      odata_n = cfg_data;
      errc_n  = err_count;
      words_n = words_loaded;
      win_s   = {win[6:0], sin};
      unique case (state)
         HUNT: begin
            if (sen) begin
               if (win_s == SYNC) begin
                  state_n = ADDR;
                  win_n   = '0;
                  cnt_n   = '0;
               end else begin
                  win_n = win_s;
               end
            end
         end
         ADDR: begin
            if (sen) begin
               sa_n  = {sa[6:0], sin};
               cnt_n = cnt + CW'(1);
               if (cnt == LAST8) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end
            end
         end
         DATA: begin
            if (sen) begin
               sd_n  = {sd[DATA_W-2:0], sin};
               cnt_n = cnt + CW'(1);
               if (cnt == LASTD) begin
                  state_n = CHK;
                  cnt_n   = '0;
               end
            end
         end
         CHK: begin
            if (sen) begin
               sc_n  = {sc[6:0], sin};
               cnt_n = cnt + CW'(1);
               if (cnt == LAST8) begin
                  state_n = EVAL;
                  cnt_n   = '0;
               end
            end
         end
         EVAL: begin
            state_n = HUNT;
            if (calc != sc) begin
               err_n  = 1'b1;
               errc_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            end else if (sa == 8'hFF && sd == '0) begin
               done_n  = 1'b1;
               state_n = DONE;
            end else if ({1'b0, sa} >= NT) begin
               err_n  = 1'b1;
               errc_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            end else begin
               we_n    = 1'b1;
               oaddr_n = sa;
               odata_n = sd;
               words_n = (words_loaded == 8'hFF) ? words_loaded
                                                 : words_loaded + 8'd1;
            end
         end
         DONE: begin
            state_n = DONE;
         end
         default: begin
            state_n = HUNT;
         end
      endcase
   end

   // state, datapath and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= HUNT;
         win          <= '0;
         sa           <= '0;
         sd           <= '0;
         sc           <= '0;
         cnt          <= '0;
         cfg_we       <= 1'b0;
         cfg_err      <= 1'b0;
         cfg_done     <= 1'b0;
         cfg_addr     <= '0;
         cfg_data     <= '0;
         err_count    <= '0;
         words_loaded <= '0;
      end else begin
         state        <= state_n;
         win          <= win_n;
         sa           <= sa_n;
         sd           <= sd_n;
         sc           <= sc_n;
         cnt          <= cnt_n;
         cfg_we       <= we_n;
         cfg_err      <= err_n;
         cfg_done     <= done_n;
         cfg_addr     <= oaddr_n;
         cfg_data     <= odata_n;
         err_count    <= errc_n;
         words_loaded <= words_n;
      end
   end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: framed bitstreams with
// hand-computed expectations, checked with immediate assertions.
module tb_fpga_config_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        sin;
   logic        sen;
   logic        cfg_we;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_done;
   logic        cfg_err;
   logic [7:0]  err_count;
   logic [7:0]  words_loaded;
   logic        busy;

   localparam logic [7:0] SYNC = 8'hA5;

   int checks = 0;
   int errors = 0;
   int n_we   = 0;
   int n_err  = 0;
   int n_both = 0;
   int w0;

   fpga_config_loader dut (
      .clock        (clock),
      .reset        (reset),
      .sin          (sin),
      .sen          (sen),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .err_count    (err_count),
      .words_loaded (words_loaded),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   // strobe monitor
   always @(posedge clock) begin
      if (cfg_we) n_we++;
      if (cfg_err) n_err++;
      if (cfg_we && cfg_err) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bit_(input logic b, input bit gap);
      if (gap) begin
         sen = 1'b0;
         sin = ~b;
         tick();
      end
      sin = b;
      sen = 1'b1;
      tick();
      sen = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
      for (int i = n - 1; i >= 0; i--) begin
         bit_(v[i], gap);
      end
   endtask

   task automatic frame(input logic [7:0] a, input logic [31:0] d,
                        input logic [7:0] c, input bit gap);
      send_bits({24'd0, SYNC}, 8, gap);
      send_bits({24'd0, a}, 8, gap);
      send_bits(d, 32, gap);
      send_bits({24'd0, c}, 8, gap);
   endtask

   function automatic logic [7:0] ck(input logic [7:0] a, input logic [31:0] d);
      return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
   endfunction

   initial begin
      reset = 1'b1;
      sen   = 1'b0;
      sin   = 1'b0;
      tick();
      tick();
      chk("rst_we", cfg_we, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", cfg_addr, 0);
      chk("rst_data", cfg_data, 0);
      chk("rst_errc", err_count, 0);
      chk("rst_words", words_loaded, 0);
      reset = 1'b0;
      tick();

      // 1: plain frame, sen high throughout
      frame(8'h00, 32'hFFF0F000, 8'hFF, 1'b0);
      chk("t1_early", cfg_we, 0);
      chk("t1_eval_busy", busy, 1);
      tick();
      chk("t1_we", cfg_we, 1);
      chk("t1_addr", cfg_addr, 32'h00);
      chk("t1_data", cfg_data, 32'hFFF0F000);
      chk("t1_words", words_loaded, 1);
      chk("t1_busy", busy, 0);
      tick();
      chk("t1_we_off", cfg_we, 0);
      chk("t1_hold", cfg_data, 32'hFFF0F000);

      // 2: sen toggled, invalid cycles carry inverted noise
      frame(8'h01, 32'hF00F0FF0, 8'h01, 1'b1);
      chk("t2_early", cfg_we, 0);
      tick();
      chk("t2_we", cfg_we, 1);
      chk("t2_addr", cfg_addr, 32'h01);
      chk("t2_data", cfg_data, 32'hF00F0FF0);
      chk("t2_words", words_loaded, 2);
      tick();
      chk("t2_we_off", cfg_we, 0);

      // 3: bad checksum
      w0 = n_we;
      frame(8'h00, 32'hFFF0F000, 8'hFE, 1'b0);
      tick();
      chk("t3_err", cfg_err, 1);
      chk("t3_we", cfg_we, 0);
      chk("t3_errc", err_count, 1);
      chk("t3_hold_addr", cfg_addr, 32'h01);
      chk("t3_hold_data", cfg_data, 32'hF00F0FF0);
      tick();
      chk("t3_err_off", cfg_err, 0);
      chk("t3_no_write", n_we - w0, 0);

      // 4: out-of-range addresses, then END
      frame(8'h2B, 32'h00000000, 8'h2B, 1'b0);
      tick();
      chk("t4_range_err", cfg_err, 1);
      chk("t4_range_errc", err_count, 2);
      tick();
      frame(8'hFF, 32'h00000001, 8'hFE, 1'b0);
      tick();
      chk("t4_ff_err", cfg_err, 1);
      chk("t4_ff_errc", err_count, 3);
      tick();
      frame(8'hFF, 32'h00000000, 8'hFF, 1'b0);
      tick();
      chk("t4_done", cfg_done, 1);
      chk("t4_end_err", cfg_err, 0);
      chk("t4_end_we", cfg_we, 0);
      chk("t4_end_errc", err_count, 3);
      chk("t4_done_busy", busy, 1);
      w0 = n_we;
      frame(8'h00, 32'hFFF0F000, 8'hFF, 1'b0);
      tick();
      tick();
      chk("t4_ignored", n_we - w0, 0);
      chk("t4_words", words_loaded, 2);
      chk("t4_sticky", cfg_done, 1);
      chk("t4_err_total", n_err, 3);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_done", cfg_done, 0);
      chk("rst2_errc", err_count, 0);
      chk("rst2_words", words_loaded, 0);
      chk("rst2_addr", cfg_addr, 0);
      chk("rst2_busy", busy, 0);

      // 5: noise bits before sync; sync must land on the 11th bit
      send_bits(32'b101, 3, 1'b0);
      send_bits({25'd0, SYNC[7:1]}, 7, 1'b0);
      chk("t5_no_early_sync", busy, 0);
      bit_(SYNC[0], 1'b0);
      chk("t5_sync", busy, 1);
      send_bits(32'h05, 8, 1'b0);
      send_bits(32'h12345678, 32, 1'b0);
      send_bits(32'h0D, 8, 1'b0);
      tick();
      chk("t5_we", cfg_we, 1);
      chk("t5_addr", cfg_addr, 32'h05);
      chk("t5_data", cfg_data, 32'h12345678);
      chk("t5_words", words_loaded, 1);
      tick();

      // 5b: reset 20 bits into a frame
      w0 = n_we;
      send_bits({24'd0, SYNC}, 8, 1'b0);
      send_bits(32'h07, 8, 1'b0);
      send_bits(32'hA, 4, 1'b0);
      chk("t5r_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5r_idle", busy, 0);
      chk("t5r_words", words_loaded, 0);
      for (int i = 0; i < 50; i++) begin
         bit_(1'b0, 1'b0);
      end
      chk("t5r_no_write", n_we - w0, 0);
      frame(8'h06, 32'h00000000, 8'h06, 1'b0);
      tick();
      chk("t5r_we", cfg_we, 1);
      chk("t5r_addr", cfg_addr, 32'h06);
      chk("t5r_words2", words_loaded, 1);

      // 6: 256 back-to-back frames with a junk bit during EVAL
      w0 = n_we + 1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0]  a;
         logic [31:0] d;
         a = 8'(i % 43);
         d = {8'(i), ~8'(i), 8'h3C, 8'(i)};
         frame(a, d, ck(a, d), 1'b0);
         sin = 1'b1;
         sen = 1'b1;
         tick();
         sen = 1'b0;
         chk("t6_we", cfg_we, 1);
         chk("t6_addr", cfg_addr, {24'd0, a});
      end
      chk("t6_data", cfg_data, 32'hFF003CFF);
      tick();
      chk("t6_words_sat", words_loaded, 8'hFF);
      chk("t6_strobes", n_we - w0, 256);
      chk("t6_never_both", n_both, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
